// File: rtl/up_spi_pkg.sv
// Shared definitions for up_spi_ctl bus users: register map, CR field positions
// and the sequencer state encoding.
package up_spi_pkg;

  localparam int CR_ADDR  = 0;
  localparam int SR_ADDR  = 1;
  localparam int ODR_ADDR = 2;
  localparam int PSC_ADDR = 3;

  localparam int CR_EN     = 0;
  localparam int CR_CPOL   = 1;
  localparam int CR_CPHA   = 2;
  localparam int CR_ENTX   = 3;
  localparam int CR_DATSIZ = 8;
  localparam int CR_CS     = 16;

  typedef enum logic [2:0] {
    ST_RST_PSC = 3'd0,
    ST_IDLE    = 3'd1,
    ST_GRANT   = 3'd2,
    ST_W_DIS   = 3'd3,
    ST_W_ODR   = 3'd4,
    ST_W_CR    = 3'd5,
    ST_R_SR    = 3'd6,
    ST_FIN     = 3'd7
  } state_e;

endpackage

// File: rtl/up_spi_arb_rr.sv
// Round-robin grant over N requesters; the search starts just after the last
// granted index, and the pointer only moves when the caller confirms a grant.
module rr_arb #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
)(
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic [N-1:0]  req_i,
  input  logic          update_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  localparam logic [N-1:0] ONE = N'(1);

  logic [IW-1:0] last_q, last_d;
  logic [IW-1:0] cand;

  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(last_q) + k) % N);
      if (!any_o && req_i[cand]) begin
        any_o = 1'b1;
        idx_o = cand;
      end
    end
    gnt_o  = any_o ? (ONE << idx_o) : '0;
    last_d = (update_i && any_o) ? idx_o : last_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) last_q <= IW'(N - 1);
    else         last_q <= last_d;
  end

endmodule

// File: rtl/up_spi_arb.sv
// Shares one up_spi_ctl master among REQ_CNT requesters: programs PSC once, then
// per grant runs disable / load ODR / enable+start and polls SR until idle.
module up_spi_arb
  import up_spi_pkg::*;
#(
  parameter int          ADDRESS_WIDTH = 12,
  parameter int          REQ_CNT       = 4,
  parameter int          CS_CNT        = 2,
  parameter logic [31:0] PSC_VAL       = 32'd4,
  parameter logic [15:0] POLL_MAX      = 16'd1023
)(
  input  logic                    up_clk,
  input  logic                    up_rstn,
  input  logic [REQ_CNT-1:0]      req_valid,
  output logic [REQ_CNT-1:0]      req_ready,
  input  logic [REQ_CNT*32-1:0]   req_data,
  input  logic [REQ_CNT*6-1:0]    req_size,
  input  logic [REQ_CNT*CS_CNT-1:0] req_cs,
  input  logic [REQ_CNT*2-1:0]    req_mode,
  output logic [REQ_CNT-1:0]      req_done,
  output logic [REQ_CNT-1:0]      req_err,
  output logic                    m_wreq,
  output logic [ADDRESS_WIDTH-1:0] m_waddr,
  output logic [31:0]             m_wdata,
  input  logic                    m_wack,
  output logic                    m_rreq,
  output logic [ADDRESS_WIDTH-1:0] m_raddr,
  input  logic [31:0]             m_rdata,
  input  logic                    m_rack,
  output logic                    busy
);

  localparam int AWW = ADDRESS_WIDTH;
  localparam int IW  = (REQ_CNT > 1) ? $clog2(REQ_CNT) : 1;
  localparam logic [REQ_CNT-1:0] ONE = REQ_CNT'(1);
  localparam logic [AWW-1:0] A_CR  = AWW'(CR_ADDR);
  localparam logic [AWW-1:0] A_SR  = AWW'(SR_ADDR);
  localparam logic [AWW-1:0] A_ODR = AWW'(ODR_ADDR);
  localparam logic [AWW-1:0] A_PSC = AWW'(PSC_ADDR);

  state_e              state_q, state_d;
  logic                psc_sent_q, psc_sent_d;
  logic                err_q, err_d;
  logic [15:0]         poll_q, poll_d;
  logic [IW-1:0]       gnt_q, gnt_d;
  logic [31:0]         data_q, data_d;
  logic [5:0]          size_q, size_d;
  logic [CS_CNT-1:0]   cs_q, cs_d;
  logic [1:0]          mode_q, mode_d;
  logic                wreq_q, wreq_d, rreq_q, rreq_d;
  logic [AWW-1:0]      waddr_q, waddr_d, raddr_q, raddr_d;
  logic [31:0]         wdata_q, wdata_d;

  logic [REQ_CNT-1:0]  arb_gnt;
  logic [IW-1:0]       arb_idx;
  logic                arb_any, arb_upd;
  logic [31:0]         cr_word;
  logic                unused_rdata;

  assign unused_rdata = ^m_rdata[31:1];
  assign arb_upd      = (state_q == ST_GRANT);

  rr_arb #(.N(REQ_CNT), .IW(IW)) u_rr_arb (
    .clk_i    (up_clk),
    .rstn_i   (up_rstn),
    .req_i    (req_valid),
    .update_i (arb_upd),
    .gnt_o    (arb_gnt),
    .idx_o    (arb_idx),
    .any_o    (arb_any)
  );

  assign cr_word = (32'(cs_q) << CR_CS) | (32'(size_q) << CR_DATSIZ)
                 | (32'd1 << CR_ENTX) | (32'(mode_q[1]) << CR_CPHA)
                 | (32'(mode_q[0]) << CR_CPOL) | (32'd1 << CR_EN);

  always_comb begin
    state_d    = state_q;
    psc_sent_d = psc_sent_q;
    err_d      = err_q;
    poll_d     = poll_q;
    gnt_d      = gnt_q;
    data_d     = data_q;
    size_d     = size_q;
    cs_d       = cs_q;
    mode_d     = mode_q;
    wreq_d     = 1'b0;
    rreq_d     = 1'b0;
    waddr_d    = waddr_q;
    raddr_d    = raddr_q;
    wdata_d    = wdata_q;
    req_ready  = '0;
    req_done   = '0;
    req_err    = '0;
    unique case (state_q)
      ST_RST_PSC: begin
        if (!psc_sent_q) begin
          psc_sent_d = 1'b1;
          wreq_d     = 1'b1;
          waddr_d    = A_PSC;
          wdata_d    = PSC_VAL;
        end else if (m_wack) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: if (|req_valid) state_d = ST_GRANT;
      ST_GRANT: begin
        if (arb_any) begin
          gnt_d     = arb_idx;
          data_d    = req_data[32*int'(arb_idx) +: 32];
          size_d    = req_size[6*int'(arb_idx) +: 6];
          cs_d      = req_cs[CS_CNT*int'(arb_idx) +: CS_CNT];
          mode_d    = req_mode[2*int'(arb_idx) +: 2];
          req_ready = arb_gnt;
          state_d   = ST_W_DIS;
          wreq_d    = 1'b1;
          waddr_d   = A_CR;
          wdata_d   = 32'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_W_DIS: if (m_wack) begin
        state_d = ST_W_ODR;
        wreq_d  = 1'b1;
        waddr_d = A_ODR;
        wdata_d = data_q;
      end
      ST_W_ODR: if (m_wack) begin
        state_d = ST_W_CR;
        wreq_d  = 1'b1;
        waddr_d = A_CR;
        wdata_d = cr_word;
      end
      ST_W_CR: if (m_wack) begin
        state_d = ST_R_SR;
        rreq_d  = 1'b1;
        raddr_d = A_SR;
      end
      ST_R_SR: if (m_rack) begin
        if (!m_rdata[0]) begin
          state_d = ST_FIN;
          err_d   = 1'b0;
        end else if (poll_q >= POLL_MAX) begin
          // abort write is launched on FIN entry so FIN only waits for its ack
          state_d = ST_FIN;
          err_d   = 1'b1;
          wreq_d  = 1'b1;
          waddr_d = A_CR;
          wdata_d = 32'd0;
        end else begin
          poll_d = 16'(poll_q + 16'd1);
          rreq_d = 1'b1;
        end
      end
      ST_FIN: begin
        if (!err_q) begin
          req_done = ONE << gnt_q;
          poll_d   = '0;
          state_d  = ST_IDLE;
        end else if (m_wack) begin
          req_err = ONE << gnt_q;
          poll_d  = '0;
          err_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_RST_PSC;
    endcase
  end

  always_ff @(posedge up_clk) begin
    if (!up_rstn) begin
      state_q    <= ST_RST_PSC;
      psc_sent_q <= 1'b0;
      err_q      <= 1'b0;
      poll_q     <= '0;
      gnt_q      <= '0;
      data_q     <= '0;
      size_q     <= '0;
      cs_q       <= '0;
      mode_q     <= '0;
      wreq_q     <= 1'b0;
      rreq_q     <= 1'b0;
      waddr_q    <= '0;
      raddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      psc_sent_q <= psc_sent_d;
      err_q      <= err_d;
      poll_q     <= poll_d;
      gnt_q      <= gnt_d;
      data_q     <= data_d;
      size_q     <= size_d;
      cs_q       <= cs_d;
      mode_q     <= mode_d;
      wreq_q     <= wreq_d;
      rreq_q     <= rreq_d;
      waddr_q    <= waddr_d;
      raddr_q    <= raddr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign m_wreq  = wreq_q;
  assign m_rreq  = rreq_q;
  assign m_waddr = waddr_q;
  assign m_raddr = raddr_q;
  assign m_wdata = wdata_q;
  assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_up_spi_arb.sv
// Directed bench for up_spi_arb with a configurable-latency up-bus slave model.
module tb_up_spi_arb;

  logic         up_clk = 1'b0;
  logic         up_rstn;
  logic [3:0]   req_valid = '0;
  logic [3:0]   req_ready, req_done, req_err;
  logic [127:0] req_data = '0;
  logic [23:0]  req_size = '0;
  logic [7:0]   req_cs = '0;
  logic [7:0]   req_mode = '0;
  logic         m_wreq, m_rreq, busy;
  logic [11:0]  m_waddr, m_raddr;
  logic [31:0]  m_wdata;
  logic         m_wack = 1'b0, m_rack = 1'b0;
  logic [31:0]  m_rdata = 32'hFFFF_FFFF;

  int errors = 0;
  int checks = 0;

  up_spi_arb #(
    .ADDRESS_WIDTH(12), .REQ_CNT(4), .CS_CNT(2),
    .PSC_VAL(32'd4), .POLL_MAX(16'd3)
  ) dut (
    .up_clk(up_clk), .up_rstn(up_rstn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_size(req_size), .req_cs(req_cs), .req_mode(req_mode),
    .req_done(req_done), .req_err(req_err),
    .m_wreq(m_wreq), .m_waddr(m_waddr), .m_wdata(m_wdata), .m_wack(m_wack),
    .m_rreq(m_rreq), .m_raddr(m_raddr), .m_rdata(m_rdata), .m_rack(m_rack),
    .busy(busy)
  );

  always #5 up_clk = ~up_clk;

  // slave model and logs
  int ack_dly = 1;
  int sr_busy_left = 0;
  int wcd = 0, rcd = 0;
  int ncyc = 0;
  logic [11:0] wa_hold, ra_hold;
  logic [31:0] wd_hold, rresp;
  int w_addr_q[$];
  logic [31:0] w_data_q[$];
  int w_cyc_q[$];
  int rd_cnt, strobe_viol, hold_viol, both_viol, oh_viol;
  int rdy_idx_q[$];
  int rdy_cyc_q[$];
  int done_cnt[4];
  int err_cnt[4];
  int ev_cnt = 0;
  int last_done_cyc, last_err_cyc;
  logic [3:0] drop_mask = '0;

  always @(posedge up_clk) begin
    m_wack  <= 1'b0;
    m_rack  <= 1'b0;
    m_rdata <= 32'hFFFF_FFFF;
    if (!up_rstn) begin
      wcd = 0;
      rcd = 0;
    end
    if (m_wreq) begin
      if (wcd > 0) strobe_viol++;
      w_addr_q.push_back(int'(m_waddr));
      w_data_q.push_back(m_wdata);
      w_cyc_q.push_back(ncyc);
      wa_hold = m_waddr;
      wd_hold = m_wdata;
      wcd = ack_dly;
    end else if (wcd > 0 && (m_waddr !== wa_hold || m_wdata !== wd_hold)) begin
      hold_viol++;
    end
    if (wcd > 0) begin
      wcd--;
      if (wcd == 0) m_wack <= 1'b1;
    end
    if (m_rreq) begin
      if (rcd > 0) strobe_viol++;
      rd_cnt++;
      ra_hold = m_raddr;
      if (sr_busy_left != 0) begin
        rresp = 32'h0000_0001;
        if (sr_busy_left > 0) sr_busy_left--;
      end else begin
        rresp = 32'hFFFF_FFFE;
      end
      rcd = ack_dly;
    end else if (rcd > 0 && m_raddr !== ra_hold) begin
      hold_viol++;
    end
    if (rcd > 0) begin
      rcd--;
      if (rcd == 0) begin
        m_rack  <= 1'b1;
        m_rdata <= rresp;
      end
    end
  end

  function automatic int oh2i(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  always @(negedge up_clk) begin
    if (m_wreq && m_rreq) both_viol++;
    if (req_ready != 4'b0) begin
      rdy_idx_q.push_back(oh2i(req_ready));
      rdy_cyc_q.push_back(ncyc);
      if ($countones(req_ready) != 1) oh_viol++;
      drop_mask = drop_mask | req_ready;
    end
    for (int i = 0; i < 4; i++) begin
      if (req_done[i]) begin done_cnt[i]++; ev_cnt++; last_done_cyc = ncyc; end
      if (req_err[i])  begin err_cnt[i]++;  ev_cnt++; last_err_cyc  = ncyc; end
    end
    ncyc++;
  end

  // requester drops valid once its grant has been captured
  always @(posedge up_clk) begin
    #1;
    req_valid = req_valid & ~drop_mask;
    drop_mask = '0;
  end

  function automatic int wa(input int i);
    return (i < w_addr_q.size()) ? w_addr_q[i] : -1;
  endfunction
  function automatic logic [31:0] wd(input int i);
    return (i < w_data_q.size()) ? w_data_q[i] : 32'hDEAD_BEEF;
  endfunction
  function automatic int ri(input int i);
    return (i < rdy_idx_q.size()) ? rdy_idx_q[i] : -1;
  endfunction
  function automatic int rc(input int i);
    return (i < rdy_cyc_q.size()) ? rdy_cyc_q[i] : -1;
  endfunction

  task automatic clear_logs;
    w_addr_q.delete(); w_data_q.delete(); w_cyc_q.delete();
    rdy_idx_q.delete(); rdy_cyc_q.delete();
    rd_cnt = 0; strobe_viol = 0; hold_viol = 0; both_viol = 0; oh_viol = 0;
    for (int i = 0; i < 4; i++) begin done_cnt[i] = 0; err_cnt[i] = 0; end
  endtask

  task automatic set_req(input int i, input logic [31:0] d, input logic [5:0] s,
                         input logic [1:0] c, input logic [1:0] m);
    req_data[32*i +: 32] = d;
    req_size[6*i +: 6]   = s;
    req_cs[2*i +: 2]     = c;
    req_mode[2*i +: 2]   = m;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge up_clk);
      if (!busy) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_events(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge up_clk);
      if (ev_cnt >= target) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    bit ok;
    up_rstn = 1'b0;
    repeat (3) @(negedge up_clk);
    checks++; if (m_wreq !== 1'b0) begin errors++; $display("FAIL rst_wreq got=%b exp=0", m_wreq); end
    checks++; if (m_rreq !== 1'b0) begin errors++; $display("FAIL rst_rreq got=%b exp=0", m_rreq); end
    checks++; if (m_waddr !== 12'h0 || m_raddr !== 12'h0 || m_wdata !== 32'h0) begin
      errors++; $display("FAIL rst_bus got=%h/%h/%h exp=0/0/0", m_waddr, m_raddr, m_wdata); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_busy got=%b exp=1", busy); end
    checks++; if ({req_ready, req_done, req_err} !== 12'h0) begin
      errors++; $display("FAIL rst_pulses got=%h exp=0", {req_ready, req_done, req_err}); end
    clear_logs();
    up_rstn = 1'b1;
    wait_idle(40, ok);
    checks++; if (!ok) begin errors++; $display("FAIL psc_idle_timeout got=busy exp=idle"); end
    repeat (10) @(negedge up_clk);
    checks++; if (w_addr_q.size() !== 1) begin errors++; $display("FAIL psc_write_count got=%0d exp=1", w_addr_q.size()); end
    checks++; if (wa(0) !== 3 || wd(0) !== 32'd4) begin
      errors++; $display("FAIL psc_write got=(%0d,%h) exp=(3,00000004)", wa(0), wd(0)); end
    checks++; if (rd_cnt !== 0 || busy !== 1'b0) begin
      errors++; $display("FAIL psc_quiet got=reads %0d busy %b exp=reads 0 busy 0", rd_cnt, busy); end
  endtask

  task automatic test_single;
    bit ok; int lat; int tgt;
    clear_logs();
    ack_dly = 1; sr_busy_left = 3;
    set_req(0, 32'hA500_0000, 6'd7, 2'b01, 2'b00);
    tgt = ev_cnt + 1;
    req_valid[0] = 1'b1;
    lat = -1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge up_clk);
      if (req_ready[0]) begin lat = k; break; end
    end
    checks++; if (lat !== 1) begin errors++; $display("FAIL valid_to_ready got=%0d exp=1", lat); end
    wait_events(tgt, 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_done_timeout got=none exp=done"); end
    checks++; if (w_addr_q.size() !== 3 || wa(0) !== 0 || wd(0) !== 32'h0) begin
      errors++; $display("FAIL single_w_dis got=n%0d (%0d,%h) exp=n3 (0,00000000)", w_addr_q.size(), wa(0), wd(0)); end
    checks++; if (wa(1) !== 2 || wd(1) !== 32'hA500_0000) begin
      errors++; $display("FAIL single_w_odr got=(%0d,%h) exp=(2,a5000000)", wa(1), wd(1)); end
    checks++; if (wa(2) !== 0 || wd(2) !== 32'h0001_0709) begin
      errors++; $display("FAIL single_w_cr got=(%0d,%h) exp=(0,00010709)", wa(2), wd(2)); end
    checks++; if (rd_cnt !== 4) begin errors++; $display("FAIL single_sr_reads got=%0d exp=4", rd_cnt); end
    checks++; if (done_cnt[0] !== 1 || err_cnt[0] !== 0) begin
      errors++; $display("FAIL single_done got=done %0d err %0d exp=1 0", done_cnt[0], err_cnt[0]); end
    checks++; if (last_done_cyc - rc(0) !== 15) begin
      errors++; $display("FAIL single_grant_to_done got=%0d exp=15", last_done_cyc - rc(0)); end
    wait_idle(10, ok);
  endtask

  task automatic test_round_robin;
    bit ok; int tgt;
    clear_logs();
    ack_dly = 1; sr_busy_left = 0;
    for (int i = 1; i < 4; i++) set_req(i, 32'h1000_0000 * i, 6'd15, 2'b11, 2'b01);
    tgt = ev_cnt + 3;
    req_valid = req_valid | 4'b1110;
    wait_events(tgt, 200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rr_timeout got=%0d exp=%0d events", ev_cnt, tgt); end
    checks++; if (ri(0) !== 1 || ri(1) !== 2 || ri(2) !== 3) begin
      errors++; $display("FAIL rr_order got=%0d,%0d,%0d exp=1,2,3", ri(0), ri(1), ri(2)); end
    checks++; if (rc(1) - rc(0) !== 11) begin
      errors++; $display("FAIL back_to_back_gap got=%0d exp=11", rc(1) - rc(0)); end
    wait_idle(10, ok);
    set_req(0, 32'hFFFF_0000, 6'd0, 2'b00, 2'b10);
    tgt = ev_cnt + 2;
    req_valid = req_valid | 4'b0011;
    wait_events(tgt, 200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rr2_timeout got=%0d exp=%0d events", ev_cnt, tgt); end
    checks++; if (ri(3) !== 0 || ri(4) !== 1) begin
      errors++; $display("FAIL rr_wrap_order got=%0d,%0d exp=0,1", ri(3), ri(4)); end
    checks++; if (done_cnt[1] !== 2 || oh_viol !== 0) begin
      errors++; $display("FAIL rr_done_count got=%0d onehot_viol %0d exp=2 0", done_cnt[1], oh_viol); end
    wait_idle(10, ok);
  endtask

  task automatic test_timeout;
    bit ok; int tgt;
    clear_logs();
    ack_dly = 1; sr_busy_left = -1;
    set_req(2, 32'h1234_5678, 6'd31, 2'b10, 2'b11);
    tgt = ev_cnt + 1;
    req_valid[2] = 1'b1;
    wait_events(tgt, 100, ok);
    sr_busy_left = 0;
    checks++; if (!ok) begin errors++; $display("FAIL to_timeout got=none exp=err"); end
    checks++; if (rd_cnt !== 4) begin errors++; $display("FAIL to_sr_reads got=%0d exp=4", rd_cnt); end
    checks++; if (wd(2) !== 32'h0002_1F0F) begin errors++; $display("FAIL to_w_cr got=%h exp=00021f0f", wd(2)); end
    checks++; if (w_addr_q.size() !== 4 || wa(3) !== 0 || wd(3) !== 32'h0) begin
      errors++; $display("FAIL to_abort got=n%0d (%0d,%h) exp=n4 (0,00000000)", w_addr_q.size(), wa(3), wd(3)); end
    checks++; if (err_cnt[2] !== 1 || (done_cnt[0]+done_cnt[1]+done_cnt[2]+done_cnt[3]) !== 0) begin
      errors++; $display("FAIL to_err got=err %0d done %0d exp=1 0", err_cnt[2], done_cnt[2]); end
    checks++; if (w_cyc_q.size() < 4 || last_err_cyc !== w_cyc_q[3]) begin
      errors++; $display("FAIL to_err_after_ack got=%0d exp=ack cycle", last_err_cyc); end
    wait_idle(10, ok);
  endtask

  task automatic test_slow_slave;
    bit ok; int tgt;
    clear_logs();
    ack_dly = 5; sr_busy_left = 3;
    set_req(0, 32'hA500_0000, 6'd7, 2'b01, 2'b00);
    tgt = ev_cnt + 1;
    req_valid[0] = 1'b1;
    wait_events(tgt, 300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL slow_timeout got=none exp=done"); end
    checks++; if (w_addr_q.size() !== 3 || wa(0) !== 0 || wd(0) !== 32'h0 || wa(1) !== 2
                  || wd(1) !== 32'hA500_0000 || wa(2) !== 0 || wd(2) !== 32'h0001_0709) begin
      errors++; $display("FAIL slow_writes got=n%0d %h %h %h exp=n3 0 a5000000 00010709",
                         w_addr_q.size(), wd(0), wd(1), wd(2)); end
    checks++; if (rd_cnt !== 4 || done_cnt[0] !== 1) begin
      errors++; $display("FAIL slow_reads_done got=%0d %0d exp=4 1", rd_cnt, done_cnt[0]); end
    checks++; if (strobe_viol !== 0 || hold_viol !== 0 || both_viol !== 0) begin
      errors++; $display("FAIL slow_protocol got=strobe %0d hold %0d both %0d exp=0 0 0",
                         strobe_viol, hold_viol, both_viol); end
    ack_dly = 1;
    wait_idle(20, ok);
  endtask

  task automatic test_reset_mid;
    bit ok; int tgt;
    clear_logs();
    ack_dly = 1; sr_busy_left = -1;
    set_req(1, 32'h0F0F_0F0F, 6'd3, 2'b00, 2'b00);
    req_valid[1] = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge up_clk);
      if (m_rreq) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL mid_reach_rsr got=no read exp=read"); end
    up_rstn = 1'b0;
    set_req(3, 32'h5555_AAAA, 6'd1, 2'b01, 2'b01);
    req_valid[3] = 1'b1;
    @(negedge up_clk);
    checks++; if (m_wreq !== 1'b0 || m_rreq !== 1'b0 || busy !== 1'b1 || req_done !== 4'h0) begin
      errors++; $display("FAIL mid_reset_strobes got=w%b r%b busy%b done%h exp=w0 r0 busy1 done0",
                         m_wreq, m_rreq, busy, req_done); end
    @(negedge up_clk);
    clear_logs();
    sr_busy_left = 0;
    tgt = ev_cnt + 1;
    up_rstn = 1'b1;
    wait_events(tgt, 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL mid_after_timeout got=none exp=done"); end
    checks++; if (wa(0) !== 3 || wd(0) !== 32'd4) begin
      errors++; $display("FAIL mid_psc_repeat got=(%0d,%h) exp=(3,00000004)", wa(0), wd(0)); end
    checks++; if (w_cyc_q.size() == 0 || rdy_cyc_q.size() == 0 || w_cyc_q[0] >= rc(0) || ri(0) !== 3) begin
      errors++; $display("FAIL mid_psc_before_grant got=grant %0d at %0d exp=grant 3 after psc", ri(0), rc(0)); end
    checks++; if (done_cnt[3] !== 1) begin errors++; $display("FAIL mid_done got=%0d exp=1", done_cnt[3]); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_slow_slave();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
